// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for the shared-memory multicycle MIPS datapath.
//   Each instruction runs over 3-5 states: fetch, decode, execute,
//   memory and writeback. FETCH, MEMRD and MEMWR wait on mem_ready.
//
//   Inputs : clk, rst_n (async, active low), opcode (IR[31:26]),
//            mem_ready (memory finishes the current access this cycle)
//   Outputs: PC control (pc_write, pc_write_cond, branch_ne, pc_source),
//            memory control (i_or_d, mem_read, mem_write, ir_write),
//            register file control (mem_to_reg, reg_dst, reg_write),
//            ALU control (alu_src_a, alu_src_b, alu_op),
//            instr_done (retire pulse), illegal_op (bad-opcode pulse),
//            state (debug view of the current state)
module multicycle_control #(
   parameter int                  OPCODE_W = 6,
   parameter logic [OPCODE_W-1:0] ADDI_OP  = 6'b010000,
   parameter bit                  BNE_EN   = 1'b1,
   parameter int                  ALUOP_W  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                branch_ne,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          pc_source,
   output logic                instr_done,
   output logic                illegal_op,
   output logic [3:0]          state
);

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
      S_IDLE   = 4'd12
   } state_t;

   // Pure-Moore control bits; registered from the next state so every
   // output comes straight off a flop and clears with the async reset.
   typedef struct packed {
      logic       fetch;      // in FETCH: ir_write/pc_write gated by mem_ready
      logic       pc_jump;    // unconditional PC load (JUMP)
      logic       pc_wcond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       done;       // retire in states that do not wait on memory
   } ctl_t;

   state_t r_state;
   state_t w_next;
   ctl_t   r_ctl;
   ctl_t   w_ctl;
   logic   w_illegal;
   state_t w_dec_next;

   // Opcode dispatch out of DECODE
   always_comb begin
      w_illegal  = 1'b0;
      w_dec_next = S_FETCH;
      if (opcode == OP_RTYPE)                     w_dec_next = S_EXEC;
      else if (opcode == OP_LW || opcode == OP_SW) w_dec_next = S_MEMADR;
      else if (opcode == ADDI_OP)                 w_dec_next = S_ADDIEX;
      else if (opcode == OP_BEQ)                  w_dec_next = S_BRANCH;
      else if (BNE_EN && opcode == OP_BNE)        w_dec_next = S_BRANCH;
      else if (opcode == OP_J)                    w_dec_next = S_JUMP;
      else                                        w_illegal  = 1'b1;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  if (mem_ready) w_next = S_DECODE;
         S_DECODE: w_next = w_dec_next;
         S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWR:  if (mem_ready) w_next = S_FETCH;
         S_EXEC:   w_next = S_ALUWB;
         S_ADDIEX: w_next = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ctl = '0;
      case (w_next)
         S_FETCH: begin
            w_ctl.fetch     = 1'b1;
            w_ctl.mem_read  = 1'b1;
            w_ctl.alu_src_b = 2'b01;
         end
         S_DECODE: w_ctl.alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            w_ctl.mem_read = 1'b1;
            w_ctl.i_or_d   = 1'b1;
         end
         S_MEMWR: begin
            w_ctl.mem_write = 1'b1;
            w_ctl.i_or_d    = 1'b1;
         end
         S_MEMWB: begin
            w_ctl.reg_write  = 1'b1;
            w_ctl.mem_to_reg = 1'b1;
            w_ctl.done       = 1'b1;
         end
         S_EXEC: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_op    = 2'b10;
         end
         S_ALUWB: begin
            w_ctl.reg_write = 1'b1;
            w_ctl.reg_dst   = 1'b1;
            w_ctl.done      = 1'b1;
         end
         S_ADDIWB: begin
            w_ctl.reg_write = 1'b1;
            w_ctl.done      = 1'b1;
         end
         S_BRANCH: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_op    = 2'b01;
            w_ctl.pc_source = 2'b01;
            w_ctl.pc_wcond  = 1'b1;
            w_ctl.done      = 1'b1;
         end
         S_JUMP: begin
            w_ctl.pc_source = 2'b10;
            w_ctl.pc_jump   = 1'b1;
            w_ctl.done      = 1'b1;
         end
         default: w_ctl = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ctl   <= '0;
      end else begin
         r_state <= w_next;
         r_ctl   <= w_ctl;
      end
   end

   // Terms gated by mem_ready or opcode stay combinational; each is ANDed
   // with a registered state term, so all of them drop with reset.
   assign ir_write      = r_ctl.fetch & mem_ready;
   assign pc_write      = (r_ctl.fetch & mem_ready) | r_ctl.pc_jump;
   assign pc_write_cond = r_ctl.pc_wcond;
   assign branch_ne     = r_ctl.pc_wcond & (opcode == OP_BNE);
   assign i_or_d        = r_ctl.i_or_d;
   assign mem_read      = r_ctl.mem_read;
   assign mem_write     = r_ctl.mem_write;
   assign mem_to_reg    = r_ctl.mem_to_reg;
   assign reg_dst       = r_ctl.reg_dst;
   assign reg_write     = r_ctl.reg_write;
   assign alu_src_a     = r_ctl.alu_src_a;
   assign alu_src_b     = r_ctl.alu_src_b;
   assign alu_op        = ALUOP_W'(r_ctl.alu_op);
   assign pc_source     = r_ctl.pc_source;
   assign illegal_op    = (r_state == S_DECODE) & w_illegal;
   assign instr_done    = r_ctl.done | illegal_op |
                          ((r_state == S_MEMWR) & mem_ready);
   assign state         = r_state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- A Moore FSM sequences each MIPS instruction over 3–5 cycles: fetch, decode, execute, memory, writeback.
- Drives the shared-memory multicycle datapath: PC, IR, ALU source muxes, register file and a unified instruction/data memory.
- Adds a memory wait handshake, optional bne support, an illegal-opcode flag and an instruction-retire pulse.

Parameters:
- OPCODE_W, 6, opcode width (instr[31:26]).
- ADDI_OP, 6'b010000, opcode decoded as addi.
- BNE_EN, 1, when 1 opcode 6'b000101 executes as bne; when 0 it is illegal.
- ALUOP_W, 2, width of alu_op (upper bits zero-extended when ALUOP_W > 2).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if the branch condition holds
- branch_ne  out  1  branch condition is "not zero" (bne)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State encoding: IDLE = 12, FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11.
- Outputs are Moore, decoded from state only, except where noted as gated by mem_ready.
- Reset:
  - rst_n low → state = IDLE asynchronously.
  - In IDLE every output is 0; state reads 12.
  - IDLE → FETCH on the first rising clk edge with rst_n high.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write = mem_ready (combinational gating).
  - Stays in FETCH while mem_ready = 0; → DECODE when mem_ready = 1.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - ADDI_OP → ADDIEX
    - 000100 → BRANCH
    - 000101 with BNE_EN = 1 → BRANCH
    - 000010 → JUMP
    - anything else → FETCH, with illegal_op = 1 and instr_done = 1
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. → MEMRD if opcode = 100011, else → MEMWR.
- MEMRD:
  - mem_read = 1, i_or_d = 1.
  - Waits on mem_ready; → MEMWB when mem_ready = 1.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. → FETCH.
- MEMWR:
  - mem_write = 1, i_or_d = 1.
  - Waits on mem_ready; on mem_ready = 1: instr_done = 1, → FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. → ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1. → FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. → ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1. → FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, pc_write_cond = 1, instr_done = 1.
  - branch_ne = 1 iff opcode = 000101.
  - → FETCH.
- JUMP: pc_source = 10, pc_write = 1, instr_done = 1. → FETCH.
- Latency with mem_ready held at 1 (cycles from FETCH to retire):
  - lw: 5
  - R-type, addi, sw: 4
  - beq, bne, j: 3
- Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all other states.
- The opcode input is not latched internally; the IR holds it stable from DECODE until the next FETCH completes.
- Reset asserted mid-instruction → IDLE immediately; no write strobe may remain asserted once rst_n is low.
- mem_read and mem_write are never both 1.
- reg_write is 1 only in MEMWB, ALUWB and ADDIWB.

Test Plan:
- Reset release with mem_ready = 1, opcode = 000000 → state sequence 12, 0, 1, 6, 7, 0. reg_write = 1 and reg_dst = 1 only in state 7; instr_done pulses once.
- lw (100011) with mem_ready low 2 cycles in FETCH and 1 cycle in MEMRD → 8 cycles from FETCH to retire. ir_write = 1 only on the FETCH cycle where mem_ready = 1; MEMWB has mem_to_reg = 1.
- sw (101011) → FETCH, DECODE, MEMADR, MEMWR. mem_write = 1 and i_or_d = 1 in MEMWR; reg_write never 1.
- beq, then bne (000101) with BNE_EN = 1 → BRANCH has alu_op = 01 and pc_write_cond = 1 in both; branch_ne = 0 for beq, 1 for bne. With BNE_EN = 0, bne gives an illegal_op pulse and a return to FETCH.
- j (000010) → pc_write = 1 with pc_source = 10 in JUMP. Opcode 111111 → illegal_op = 1 for one cycle in DECODE, then FETCH.
- addi (ADDI_OP = 010000) with rst_n pulled low during ADDIEX → all outputs 0 immediately and state = 12. After release, FETCH follows in exactly 1 cycle.
